uart_rx: RTL and testbench

- Serial-to-parallel UART receiver; the receive-side counterpart of the team's UART transmitter.
- Idle-high line, one start bit, DATA_WIDTH data bits LSB-first, optional even/odd parity, one stop bit.
- CLK runs at PRESCALE x baud; the line is oversampled with majority voting.
- Delivers each good frame as a one-cycle DATA_VALID strobe, and flags parity and stop-bit (framing) errors.

---
 rtl/uart_rx.sv | 205 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx -- serial-to-parallel UART receiver.
//
// Frame: idle-high line, one start bit, DATA_WIDTH data bits LSB-first,
// optional even/odd parity bit, one stop bit. CLK runs at PRESCALE x baud.
// Each bit is decided by a 3-sample majority vote around mid-bit.
//
// Ports:
//   CLK        in   clock, PRESCALE x baud
//   RST        in   synchronous active-high reset
//   RX_IN      in   asynchronous serial line, idle high
//   PAR_EN     in   1 = parity bit present (latched at start of frame)
//   PAR_TYP    in   0 = even, 1 = odd parity (latched at start of frame)
//   P_DATA     out  data of the last good frame, held between good frames
//   DATA_VALID out  one-cycle pulse when P_DATA is updated
//   PAR_ERR    out  one-cycle pulse on parity mismatch
//   STP_ERR    out  one-cycle pulse when the stop bit is sampled 0
//   BUSY       out  high while a frame (or post-break wait) is in progress
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic                  BUSY
);

  localparam int EW = $clog2(PRESCALE);
  localparam int BW = $clog2(DATA_WIDTH);

  // Sample points within a bit; the vote is taken on the third one.
  localparam logic [EW-1:0] E_S0   = EW'(PRESCALE/2 - 1);
  localparam logic [EW-1:0] E_S1   = EW'(PRESCALE/2);
  localparam logic [EW-1:0] E_DEC  = EW'(PRESCALE/2 + 1);
  localparam logic [EW-1:0] E_LAST = EW'(PRESCALE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_WAIT   = 3'd5;

  logic [1:0]            sync_q, sync_d;
  logic [2:0]            state_q, state_d;
  logic [EW-1:0]         edge_q, edge_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [1:0]            smp_q, smp_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  pen_q, pen_d;
  logic                  ptyp_q, ptyp_d;
  logic                  mism_q, mism_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic                  dv_q, dv_d;
  logic                  pe_q, pe_d;
  logic                  se_q, se_d;

  logic rx_s;
  logic bit_val;
  logic in_bit;

  assign rx_s = sync_q[1];

  // Majority of the two stored samples and the live third sample; only
  // meaningful in the cycle where edge_q == E_DEC.
  assign bit_val = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);

  // States that walk through bit periods and therefore run edge_cnt.
  assign in_bit = (state_q == ST_START) || (state_q == ST_DATA) ||
                  (state_q == ST_PARITY) || (state_q == ST_STOP);

  always_comb begin
    sync_d  = {sync_q[0], RX_IN};
    state_d = state_q;
    edge_d  = edge_q;
    bit_d   = bit_q;
    smp_d   = smp_q;
    data_d  = data_q;
    pen_d   = pen_q;
    ptyp_d  = ptyp_q;
    mism_d  = mism_q;
    pdata_d = pdata_q;
    dv_d    = 1'b0;
    pe_d    = 1'b0;
    se_d    = 1'b0;

    if (in_bit) begin
      edge_d = (edge_q == E_LAST) ? '0 : edge_q + EW'(1);
      if (edge_q == E_S0) smp_d[0] = rx_s;
      if (edge_q == E_S1) smp_d[1] = rx_s;
    end

    case (state_q)
      ST_IDLE: begin
        edge_d = '0;
        bit_d  = '0;
        if (!rx_s) begin
          state_d = ST_START;
          pen_d   = PAR_EN;
          ptyp_d  = PAR_TYP;
          mism_d  = 1'b0;
        end
      end
      ST_START: begin
        if (edge_q == E_DEC && bit_val) begin
          // Start bit did not hold low through mid-bit: treat as a glitch.
          state_d = ST_IDLE;
          edge_d  = '0;
        end else if (edge_q == E_LAST) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (edge_q == E_DEC) data_d = {bit_val, data_q[DATA_WIDTH-1:1]};
        if (edge_q == E_LAST) begin
          if (bit_q == B_LAST) begin
            bit_d   = '0;
            state_d = pen_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (edge_q == E_DEC) mism_d = (bit_val != ((^data_q) ^ ptyp_q));
        if (edge_q == E_LAST) state_d = ST_STOP;
      end
      ST_STOP: begin
        // Leave mid-stop-bit so a start edge right after the nominal stop
        // bit is caught in IDLE.
        if (edge_q == E_DEC) begin
          edge_d = '0;
          if (bit_val) begin
            state_d = ST_IDLE;
            if (mism_q) begin
              pe_d = 1'b1;
            end else begin
              dv_d    = 1'b1;
              pdata_d = data_q;
            end
          end else begin
            state_d = ST_WAIT;
            se_d    = 1'b1;
            pe_d    = mism_q;
          end
        end
      end
      ST_WAIT: begin
        // A break holds the line low; only a return to high re-arms IDLE.
        edge_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        edge_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q  <= 2'b11;
      state_q <= ST_IDLE;
      edge_q  <= '0;
      bit_q   <= '0;
      smp_q   <= '0;
      data_q  <= '0;
      pen_q   <= 1'b0;
      ptyp_q  <= 1'b0;
      mism_q  <= 1'b0;
      pdata_q <= '0;
      dv_q    <= 1'b0;
      pe_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      edge_q  <= edge_d;
      bit_q   <= bit_d;
      smp_q   <= smp_d;
      data_q  <= data_d;
      pen_q   <= pen_d;
      ptyp_q  <= ptyp_d;
      mism_q  <= mism_d;
      pdata_q <= pdata_d;
      dv_q    <= dv_d;
      pe_q    <= pe_d;
      se_q    <= se_d;
    end
  end

  assign P_DATA     = pdata_q;
  assign DATA_VALID = dv_q;
  assign PAR_ERR    = pe_q;
  assign STP_ERR    = se_q;
  assign BUSY       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- self-checking bench for uart_rx (DATA_WIDTH 8, PRESCALE 8).
// Directed frames come from a table of {inputs, expected outputs}; random
// frames are checked against an event list built from the frame rules.
module tb_uart_rx;
  localparam int DW = 8;
  localparam int P  = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          RX_IN = 1'b1;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic [DW-1:0] P_DATA;
  logic          DATA_VALID, PAR_ERR, STP_ERR, BUSY;

  uart_rx #(.DATA_WIDTH(DW), .PRESCALE(P)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .P_DATA(P_DATA), .DATA_VALID(DATA_VALID), .PAR_ERR(PAR_ERR),
    .STP_ERR(STP_ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Output pulse log, one entry per high cycle, stamped with cyc.
  int            dv_cyc[$];
  logic [DW-1:0] dv_dat[$];
  int            pe_cyc[$];
  int            se_cyc[$];

  always @(negedge CLK) begin
    if (DATA_VALID) begin dv_cyc.push_back(cyc); dv_dat.push_back(P_DATA); end
    if (PAR_ERR) pe_cyc.push_back(cyc);
    if (STP_ERR) se_cyc.push_back(cyc);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_log();
    dv_cyc.delete(); dv_dat.delete(); pe_cyc.delete(); se_cyc.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  // Hold one bit for P cycles; slot gj (if >= 0) carries the inverted value.
  task automatic drive_bit(input logic b, input int gj);
    for (int j = 0; j < P; j++) begin
      RX_IN = (j == gj) ? ~b : b;
      @(posedge CLK); #1;
    end
  endtask

  // Frame bit index gbit (0 = start, 1.. = data) gets a one-sample glitch
  // at its midpoint. flip inverts PAR_EN/PAR_TYP after the start bit.
  task automatic send_frame(input logic [DW-1:0] d, input logic pen, input logic pbit,
                            input logic sbit, input int gbit, input logic flip,
                            output int c0);
    c0 = cyc + 1;  // edge where the first synchronizer flop sees the start
    drive_bit(1'b0, (gbit == 0) ? 5 : -1);
    if (flip) begin PAR_EN = ~PAR_EN; PAR_TYP = ~PAR_TYP; end
    for (int i = 0; i < DW; i++) drive_bit(d[i], (gbit == i + 1) ? 5 : -1);
    if (pen) drive_bit(pbit, -1);
    drive_bit(sbit, -1);
  endtask

  function automatic int lat(input logic pen);
    return 2 + P * (1 + DW + (pen ? 1 : 0)) + P / 2 + 2;
  endfunction

  // Parity bit that makes a correct frame: even -> total ones even.
  function automatic logic good_par(input logic [DW-1:0] d, input logic typ);
    logic odd_ones;
    odd_ones = (($countones(d) % 2) == 1);
    return typ ? ~odd_ones : odd_ones;
  endfunction

  typedef struct {
    logic [DW-1:0] d;
    logic pen, ptyp, pbit, sbit;
    int   gbit;
    logic flip;
    logic exp_dv, exp_pe, exp_se;
    logic [DW-1:0] exp_pd;
  } vec_t;

  vec_t vecs[9];

  int c0, c1, c2;
  int e_dv_cyc[$];
  logic [DW-1:0] e_dv_dat[$];
  int e_pe_cyc[$];
  int e_se_cyc[$];

  initial begin
    //          d      pen   ptyp  pbit  sbit  gbit flip  dv    pe    se    pd
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C};
    vecs[2] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C};
    vecs[3] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, -1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01};
    vecs[4] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1,  2, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
    vecs[5] = '{8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5};
    vecs[6] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C};
    vecs[7] = '{8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC3};
    vecs[8] = '{8'h12, 1'b0, 1'b0, 1'b0, 1'b1,  4, 1'b0, 1'b1, 1'b0, 1'b0, 8'h12};

    // Reset state
    RST = 1'b1; RX_IN = 1'b1;
    tick(3);
    chk("rst_pdata", 32'(P_DATA), 0);
    chk("rst_dv", 32'(DATA_VALID), 0);
    chk("rst_pe", 32'(PAR_ERR), 0);
    chk("rst_se", 32'(STP_ERR), 0);
    chk("rst_busy", 32'(BUSY), 0);
    RST = 1'b0;
    tick(2 * P);

    // Directed table
    foreach (vecs[v]) begin
      clear_log();
      PAR_EN = vecs[v].pen; PAR_TYP = vecs[v].ptyp;
      send_frame(vecs[v].d, vecs[v].pen, vecs[v].pbit, vecs[v].sbit,
                 vecs[v].gbit, vecs[v].flip, c0);
      RX_IN = 1'b1;
      tick(3 * P);
      chk($sformatf("v%0d_dv_n", v), 32'(dv_cyc.size()), 32'(vecs[v].exp_dv));
      chk($sformatf("v%0d_pe_n", v), 32'(pe_cyc.size()), 32'(vecs[v].exp_pe));
      chk($sformatf("v%0d_se_n", v), 32'(se_cyc.size()), 32'(vecs[v].exp_se));
      if (vecs[v].exp_dv && dv_cyc.size() > 0)
        chk($sformatf("v%0d_dv_cyc", v), 32'(dv_cyc[0]), 32'(c0 + lat(vecs[v].pen)));
      if (vecs[v].exp_pe && pe_cyc.size() > 0)
        chk($sformatf("v%0d_pe_cyc", v), 32'(pe_cyc[0]), 32'(c0 + lat(vecs[v].pen)));
      if (vecs[v].exp_se && se_cyc.size() > 0)
        chk($sformatf("v%0d_se_cyc", v), 32'(se_cyc[0]), 32'(c0 + lat(vecs[v].pen)));
      chk($sformatf("v%0d_pdata", v), 32'(P_DATA), 32'(vecs[v].exp_pd));
      chk($sformatf("v%0d_busy", v), 32'(BUSY), 0);
    end
    PAR_EN = 1'b0; PAR_TYP = 1'b0;

    // Framing error followed by a 40-bit break
    clear_log();
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, -1, 1'b0, c0);
    RX_IN = 1'b0;
    tick(40 * P);
    chk("brk_busy_low_line", 32'(BUSY), 1);
    chk("brk_se_n", 32'(se_cyc.size()), 1);
    if (se_cyc.size() > 0) chk("brk_se_cyc", 32'(se_cyc[0]), 32'(c0 + lat(1'b0)));
    chk("brk_dv_n", 32'(dv_cyc.size()), 0);
    chk("brk_pe_n", 32'(pe_cyc.size()), 0);
    RX_IN = 1'b1;
    tick(2 * P);
    chk("brk_busy_released", 32'(BUSY), 0);
    clear_log();
    send_frame(8'h12, 1'b0, 1'b0, 1'b1, -1, 1'b0, c0);
    tick(3 * P);
    chk("brk_next_dv_n", 32'(dv_cyc.size()), 1);
    if (dv_cyc.size() > 0) begin
      chk("brk_next_cyc", 32'(dv_cyc[0]), 32'(c0 + lat(1'b0)));
      chk("brk_next_dat", 32'(dv_dat[0]), 32'h12);
    end

    // 2-cycle low pulse on the idle line
    clear_log();
    RX_IN = 1'b0; tick(2); RX_IN = 1'b1;
    tick(12 * P);
    chk("glitch_dv_n", 32'(dv_cyc.size()), 0);
    chk("glitch_err_n", 32'(pe_cyc.size() + se_cyc.size()), 0);
    chk("glitch_busy", 32'(BUSY), 0);

    // Back-to-back frames, no idle gap
    clear_log();
    send_frame(8'h00, 1'b0, 1'b0, 1'b1, -1, 1'b0, c0);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, -1, 1'b0, c1);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, -1, 1'b0, c2);
    tick(3 * P);
    chk("b2b_dv_n", 32'(dv_cyc.size()), 3);
    if (dv_cyc.size() == 3) begin
      chk("b2b_cyc0", 32'(dv_cyc[0]), 32'(c0 + 80));
      chk("b2b_cyc1", 32'(dv_cyc[1]), 32'(c0 + 160));
      chk("b2b_cyc2", 32'(dv_cyc[2]), 32'(c0 + 240));
      chk("b2b_dat0", 32'(dv_dat[0]), 32'h00);
      chk("b2b_dat1", 32'(dv_dat[1]), 32'hFF);
      chk("b2b_dat2", 32'(dv_dat[2]), 32'h81);
    end

    // Reset during data bit 4 of a 0xF0 frame (bit 4 is high)
    clear_log();
    drive_bit(1'b0, -1);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, -1);
    RX_IN = 1'b1; tick(2);
    RST = 1'b1; tick(1);
    chk("mrst_pdata", 32'(P_DATA), 0);
    chk("mrst_dv", 32'(DATA_VALID), 0);
    chk("mrst_pe", 32'(PAR_ERR), 0);
    chk("mrst_se", 32'(STP_ERR), 0);
    chk("mrst_busy", 32'(BUSY), 0);
    RST = 1'b0;
    tick(3 * P);
    chk("mrst_no_events", 32'(dv_cyc.size() + pe_cyc.size() + se_cyc.size()), 0);
    send_frame(8'h7E, 1'b0, 1'b0, 1'b1, -1, 1'b0, c0);
    tick(3 * P);
    chk("mrst_next_dv_n", 32'(dv_cyc.size()), 1);
    if (dv_cyc.size() > 0) begin
      chk("mrst_next_cyc", 32'(dv_cyc[0]), 32'(c0 + lat(1'b0)));
      chk("mrst_next_dat", 32'(dv_dat[0]), 32'h7E);
    end

    // Random frames against the event model
    clear_log();
    e_dv_cyc.delete(); e_dv_dat.delete(); e_pe_cyc.delete(); e_se_cyc.delete();
    for (int n = 0; n < 40; n++) begin
      logic [DW-1:0] d;
      logic pen, ptyp, bad_par, sbit, pbit;
      int when, gap;
      d       = DW'($urandom);
      pen     = 1'($urandom_range(0, 1));
      ptyp    = 1'($urandom_range(0, 1));
      bad_par = pen && ($urandom_range(0, 3) == 0);
      sbit    = ($urandom_range(0, 7) != 0);
      pbit    = good_par(d, ptyp) ^ bad_par;
      PAR_EN = pen; PAR_TYP = ptyp;
      send_frame(d, pen, pbit, sbit, -1, 1'b0, c0);
      when = c0 + lat(pen);
      if (!sbit) begin
        e_se_cyc.push_back(when);
        if (bad_par) e_pe_cyc.push_back(when);
      end else if (bad_par) begin
        e_pe_cyc.push_back(when);
      end else begin
        e_dv_cyc.push_back(when);
        e_dv_dat.push_back(d);
      end
      gap = sbit ? $urandom_range(0, 2) : $urandom_range(1, 2);
      RX_IN = 1'b1;
      tick(gap * P);
    end
    RX_IN = 1'b1;
    tick(4 * P);
    chk("rnd_dv_n", 32'(dv_cyc.size()), 32'(e_dv_cyc.size()));
    chk("rnd_pe_n", 32'(pe_cyc.size()), 32'(e_pe_cyc.size()));
    chk("rnd_se_n", 32'(se_cyc.size()), 32'(e_se_cyc.size()));
    for (int i = 0; i < dv_cyc.size() && i < e_dv_cyc.size(); i++) begin
      chk($sformatf("rnd_dv_cyc%0d", i), 32'(dv_cyc[i]), 32'(e_dv_cyc[i]));
      chk($sformatf("rnd_dv_dat%0d", i), 32'(dv_dat[i]), 32'(e_dv_dat[i]));
    end
    for (int i = 0; i < pe_cyc.size() && i < e_pe_cyc.size(); i++)
      chk($sformatf("rnd_pe_cyc%0d", i), 32'(pe_cyc[i]), 32'(e_pe_cyc[i]));
    for (int i = 0; i < se_cyc.size() && i < e_se_cyc.size(); i++)
      chk($sformatf("rnd_se_cyc%0d", i), 32'(se_cyc[i]), 32'(e_se_cyc[i]));
    if (e_dv_dat.size() > 0)
      chk("rnd_pdata_hold", 32'(P_DATA), 32'(e_dv_dat[e_dv_dat.size() - 1]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
